// File: rtl/piece_motion_controller.sv
// Falling-block sequencer: synchronizes buttons, applies moves/gravity at frame boundaries,
// hands landed positions to the board over valid/ready. Optional hard drop: HARD_DROP_EN.
module piece_motion_controller #(
  parameter int GRAV_DIV  = 4194304,
  parameter int CELL      = 25,
  parameter int DROP_STEP = 25,
  parameter int BLOCK     = 50,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int X_INIT    = 50,
  parameter int Y_INIT    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_left,
  input  logic       ctrl_right,
  input  logic       ctrl_drop,
  input  logic       frame_end,
  output logic [9:0] originx,
  output logic [8:0] originy,
  output logic       lock_valid,
  output logic [9:0] lock_x,
  output logic [8:0] lock_y,
  input  logic       lock_ready,
  output logic [1:0] state
);

  // state | meaning
  // FALL  | block falling, moves committed on frame_end
  // LOCK  | landed position offered to the board
  // SPAWN | one cycle, origin back to spawn point
  // DROP  | hard drop, one step per clk until landing
  typedef enum logic [1:0] {FALL = 2'd0, LOCK = 2'd1, SPAWN = 2'd2, DROP = 2'd3} state_t;

  localparam int CW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic [CW-1:0] GMAX = CW'(GRAV_DIV - 1);
  localparam logic [10:0] CELL11  = 11'(CELL);
  localparam logic [10:0] DROP11  = 11'(DROP_STEP);
  localparam logic [10:0] BLOCK11 = 11'(BLOCK);
  localparam logic [10:0] W11     = 11'(SCREEN_W);
  localparam logic [10:0] H11     = 11'(SCREEN_H);

  state_t        st;
  logic [CW-1:0] gcnt;
  logic [1:0]    sync_l, sync_r;
  logic          prev_l, prev_r;
  logic          pend_l, pend_r, pend_g;
  logic          edge_l, edge_r, g_wrap;
  logic [10:0]   x11, y11, nx11, ny11;
  logic          can_l, can_r, can_d;

  assign state  = st;
  assign edge_l = sync_l[1] & ~prev_l;
  assign edge_r = sync_r[1] & ~prev_r;
  assign g_wrap = (gcnt == GMAX);

`ifdef HARD_DROP_EN
  logic [1:0] sync_d;
  logic       prev_d, pend_d, edge_d;
  assign edge_d = sync_d[1] & ~prev_d;
`else
  logic drop_unused;
  assign drop_unused = ctrl_drop;
`endif

  always_comb begin
    x11   = {1'b0, originx};
    y11   = {2'b0, originy};
    can_l = (x11 >= CELL11);
    can_r = (x11 + CELL11 + BLOCK11 <= W11);
    can_d = (y11 + DROP11 + BLOCK11 <= H11);
    ny11  = y11 + DROP11;
    nx11  = x11;
    if (pend_l && !pend_r && can_l)      nx11 = x11 - CELL11;
    else if (pend_r && !pend_l && can_r) nx11 = x11 + CELL11;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= FALL;
      originx    <= 10'(X_INIT);
      originy    <= 9'(Y_INIT);
      lock_valid <= 1'b0;
      lock_x     <= '0;
      lock_y     <= '0;
      gcnt       <= '0;
      sync_l     <= '0;
      sync_r     <= '0;
      prev_l     <= 1'b0;
      prev_r     <= 1'b0;
      pend_l     <= 1'b0;
      pend_r     <= 1'b0;
      pend_g     <= 1'b0;
`ifdef HARD_DROP_EN
      sync_d     <= '0;
      prev_d     <= 1'b0;
      pend_d     <= 1'b0;
`endif
    end else begin
      sync_l <= {sync_l[0], ctrl_left};
      sync_r <= {sync_r[0], ctrl_right};
      prev_l <= sync_l[1];
      prev_r <= sync_r[1];
`ifdef HARD_DROP_EN
      sync_d <= {sync_d[0], ctrl_drop};
      prev_d <= sync_d[1];
`endif
      case (st)
        FALL: begin
          gcnt <= g_wrap ? '0 : gcnt + 1'b1;
          if (frame_end) begin
            // same-cycle edges/wraps belong to the next frame
            originx <= nx11[9:0];
            pend_l  <= edge_l;
            pend_r  <= edge_r;
            pend_g  <= g_wrap;
`ifdef HARD_DROP_EN
            pend_d  <= edge_d;
            if (pend_d) begin
              st     <= DROP;
              gcnt   <= '0;
              pend_l <= 1'b0;
              pend_r <= 1'b0;
              pend_g <= 1'b0;
              pend_d <= 1'b0;
            end else
`endif
            if (pend_g) begin
              if (can_d) begin
                originy <= ny11[8:0];
              end else begin
                st         <= LOCK;
                lock_valid <= 1'b1;
                lock_x     <= nx11[9:0];
                lock_y     <= originy;
                gcnt       <= '0;
                pend_l     <= 1'b0;
                pend_r     <= 1'b0;
                pend_g     <= 1'b0;
`ifdef HARD_DROP_EN
                pend_d     <= 1'b0;
`endif
              end
            end
          end else begin
            pend_l <= pend_l | edge_l;
            pend_r <= pend_r | edge_r;
            pend_g <= pend_g | g_wrap;
`ifdef HARD_DROP_EN
            pend_d <= pend_d | edge_d;
`endif
          end
        end
        LOCK: begin
          gcnt   <= '0;
          pend_l <= 1'b0;
          pend_r <= 1'b0;
          pend_g <= 1'b0;
          if (lock_ready) begin
            st         <= SPAWN;
            lock_valid <= 1'b0;
          end
        end
        SPAWN: begin
          gcnt    <= '0;
          pend_l  <= 1'b0;
          pend_r  <= 1'b0;
          pend_g  <= 1'b0;
          originx <= 10'(X_INIT);
          originy <= 9'(Y_INIT);
          st      <= FALL;
        end
        DROP: begin
          gcnt   <= '0;
          pend_l <= 1'b0;
          pend_r <= 1'b0;
          pend_g <= 1'b0;
`ifdef HARD_DROP_EN
          if (can_d) begin
            originy <= ny11[8:0];
          end else begin
            st         <= LOCK;
            lock_valid <= 1'b1;
            lock_x     <= originx;
            lock_y     <= originy;
          end
`else
          st <= FALL;
`endif
        end
        default: st <= FALL;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_motion_controller.sv
// Directed bench: horizontal moves on a slow-gravity instance, gravity/lock/drop on a GRAV_DIV=8 instance.
module tb_piece_motion_controller;

  logic clk = 1'b0;
  logic reset, ctrl_left, ctrl_right, ctrl_drop, frame_end, lock_ready;
  logic [9:0] gx, hx, glx, hlx;
  logic [8:0] gy, hy, gly, hly;
  logic       glv, hlv;
  logic [1:0] gst, hst;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piece_motion_controller #(.GRAV_DIV(8)) dut_g (
    .clk(clk), .reset(reset), .ctrl_left(ctrl_left), .ctrl_right(ctrl_right),
    .ctrl_drop(ctrl_drop), .frame_end(frame_end), .originx(gx), .originy(gy),
    .lock_valid(glv), .lock_x(glx), .lock_y(gly), .lock_ready(lock_ready), .state(gst));

  // gravity effectively off during the horizontal sweep
  piece_motion_controller #(.GRAV_DIV(1 << 20)) dut_h (
    .clk(clk), .reset(reset), .ctrl_left(ctrl_left), .ctrl_right(ctrl_right),
    .ctrl_drop(ctrl_drop), .frame_end(frame_end), .originx(hx), .originy(hy),
    .lock_valid(hlv), .lock_x(hlx), .lock_y(hly), .lock_ready(lock_ready), .state(hst));

  typedef struct {
    logic l;
    logic r;
    int   x;
  } vec_t;

  vec_t vecs[51];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 20-clk frame: optional button pulse, then frame_end on the last cycle
  task automatic frame(input logic l, input logic r, input logic d);
    ctrl_left = l; ctrl_right = r; ctrl_drop = d;
    tick(4);
    ctrl_left = 0; ctrl_right = 0; ctrl_drop = 0;
    tick(15);
    frame_end = 1;
    tick(1);
    frame_end = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick(3);
    reset = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hx"}, hx, 50);   chk({tag, "_hy"}, hy, 50);
    chk({tag, "_hst"}, hst, 0);  chk({tag, "_hlv"}, hlv, 0);
    chk({tag, "_gx"}, gx, 50);   chk({tag, "_gy"}, gy, 50);
    chk({tag, "_gst"}, gst, 0);  chk({tag, "_glv"}, glv, 0);
    chk({tag, "_glx"}, glx, 0);  chk({tag, "_gly"}, gly, 0);
  endtask

  initial begin
    reset = 1; ctrl_left = 0; ctrl_right = 0; ctrl_drop = 0;
    frame_end = 0; lock_ready = 0;

    for (int i = 0; i < 24; i++) vecs[i] = '{1'b0, 1'b1, (50 + 25 * (i + 1) > 575) ? 575 : 50 + 25 * (i + 1)};
    for (int j = 0; j < 24; j++) vecs[24 + j] = '{1'b1, 1'b0, (575 - 25 * (j + 1) < 0) ? 0 : 575 - 25 * (j + 1)};
    vecs[48] = '{1'b1, 1'b1, 0};
    vecs[49] = '{1'b0, 1'b1, 25};
    vecs[50] = '{1'b1, 1'b1, 25};

    tick(3);
    reset = 0;
    chk_reset("rst0");

    for (int k = 0; k < 51; k++) begin
      frame(vecs[k].l, vecs[k].r, 1'b0);
      chk($sformatf("hmove%0d_x", k), hx, vecs[k].x);
      chk($sformatf("hmove%0d_y", k), hy, 50);
    end

    // reset mid-FALL with a pending press (dut_g is sitting in LOCK with lock_valid high)
    chk("pre_rst_glv", glv, 1);
    ctrl_right = 1;
    tick(4);
    ctrl_right = 0;
    do_reset();
    chk_reset("rst_mid");
    frame(1'b0, 1'b0, 1'b0);
    chk("post_rst_hx", hx, 50);

    // gravity to landing
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      frame(1'b0, 1'b0, 1'b0);
      chk($sformatf("grav%0d_y", k), gy, 50 + 25 * k);
      chk($sformatf("grav%0d_st", k), gst, 0);
    end
    frame(1'b0, 1'b0, 1'b0);
    chk("land_st", gst, 1);
    chk("land_lv", glv, 1);
    chk("land_ly", gly, 425);
    chk("land_lx", glx, 50);

    // lock held while lock_ready low; a press during LOCK must be discarded
    for (int c = 0; c < 10; c++) begin
      ctrl_right = (c < 4);
      tick(1);
      chk($sformatf("hold%0d", c), {gst, glv, gly, glx}, {2'd1, 1'b1, 9'd425, 10'd50});
    end
    ctrl_right = 0;
    lock_ready = 1;
    tick(1);
    lock_ready = 0;
    chk("spawn_st", gst, 2);
    chk("spawn_lv", glv, 0);
    tick(1);
    chk("refall_st", gst, 0);
    chk("refall_x", gx, 50);
    chk("refall_y", gy, 50);
    frame(1'b0, 1'b0, 1'b0);
    chk("nopend_x", gx, 50);
    chk("nopend_y", gy, 75);

    do_reset();
    frame(1'b0, 1'b0, 1'b1);
`ifdef HARD_DROP_EN
    chk("drop_st", gst, 3);
    chk("drop_y0", gy, 50);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      chk($sformatf("drop%0d_y", k), gy, 50 + 25 * k);
      chk($sformatf("drop%0d_st", k), gst, 3);
    end
    tick(1);
    chk("drop_lock_st", gst, 1);
    chk("drop_lock_lv", glv, 1);
    chk("drop_lock_ly", gly, 425);
    lock_ready = 1;
    tick(1);
    lock_ready = 0;
    tick(1);
    chk("drop_respawn_st", gst, 0);
    chk("drop_respawn_y", gy, 50);
`else
    chk("nodrop_st", gst, 0);
    chk("nodrop_y", gy, 75);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
